// File: rtl/jpeg_enc_pkg.sv
// Shared symbol layout and constants for the JPEG run-length/category encoder.
// Pure declarations, no logic and no latency.
// No flow control here; the encoder top owns all handshaking.
package jpeg_enc_pkg;

  // Upper byte of every emitted symbol: {run[3:0], size[3:0]}
  typedef struct packed {
    logic [3:0] run;
    logic [3:0] size;
  } rle_sym_t;

  localparam rle_sym_t ZRL_SYM = '{run: 4'd15, size: 4'd0};
  localparam rle_sym_t EOB_SYM = '{run: 4'd0,  size: 4'd0};

  // Zeros absorbed by one ZRL symbol
  localparam logic [5:0] ZRL_SPAN = 6'd16;
  // Zig-zag index of the final coefficient in a block
  localparam logic [5:0] LAST_IDX = 6'd63;

  // Amplitude must hold a DC difference, one bit wider than a coefficient
  function automatic int amp_width(input int dct_width);
    return dct_width + 1;
  endfunction

  // Bit positions of the run and size fields in the symbol word
  function automatic int run_msb(input int aw);
    return aw + 7;
  endfunction

  function automatic int size_msb(input int aw);
    return aw + 3;
  endfunction

endpackage

// File: rtl/jpeg_size_cat.sv
// JPEG magnitude category (size) and amplitude bits of a signed value.
// Purely combinational, zero latency.
// No flow control; result follows the input in the same cycle.
module jpeg_size_cat #(
  parameter int AMP_WIDTH = 13
) (
  input  logic [AMP_WIDTH-1:0] value,
  output logic [3:0]           size,
  output logic [AMP_WIDTH-1:0] amp
);

  logic                 neg;
  logic [AMP_WIDTH-1:0] mag;
  logic [AMP_WIDTH-1:0] mask;

  assign neg  = value[AMP_WIDTH-1];
  // Legal inputs never reach the most negative code, so negation cannot overflow
  assign mag  = neg ? (~value + AMP_WIDTH'(1)) : value;
  assign mask = ~({AMP_WIDTH{1'b1}} << size);

  // Size is the position of the highest set bit of the magnitude
  always_comb begin
    size = 4'd0;
    for (int i = 0; i < AMP_WIDTH; i++) begin
      if (mag[i]) size = 4'(i + 1);
    end
  end

  // Negative values are sent as the low 'size' bits of (v - 1)
  always_comb begin
    amp = value;
    if (neg) amp = (value - AMP_WIDTH'(1)) & mask;
  end

endmodule

// File: rtl/jpeg_rle_enc.sv
// Run-length/category encoder: zig-zag coefficients in, DC/AC/ZRL/EOB symbols out.
// Latency: 1 cycle from accepted coefficient to symbol valid (single output register).
// Backpressure: zz_tready drops while the output register is held or ZRLs are pending.
module jpeg_rle_enc
  import jpeg_enc_pkg::*;
#(
  parameter int DCT_WIDTH = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   zz_tvalid,
  output logic                   zz_tready,
  input  logic [DCT_WIDTH-1:0]   zz_tdata,
  input  logic                   zz_tuser,
  input  logic                   zz_tlast,
  output logic                   rle_tvalid,
  input  logic                   rle_tready,
  output logic [DCT_WIDTH+8:0]   rle_tdata,
  output logic                   rle_tuser,
  output logic                   rle_tlast
);

  localparam int AMP_WIDTH = amp_width(DCT_WIDTH);

  typedef enum logic {S_PASS, S_HOLD} state_t;

  state_t               state_q, state_d;
  logic [5:0]           coef_idx_q, coef_idx_d;
  logic [5:0]           run_q, run_d;
  logic [DCT_WIDTH-1:0] dc_pred_q, dc_pred_d;
  logic [DCT_WIDTH-1:0] hold_q;
  logic                 hold_last_q;
  logic                 hold_ld;

  logic                 out_free, accept, run_ge16;
  logic [DCT_WIDTH-1:0] pred_base;
  logic [AMP_WIDTH-1:0] coef_ext, hold_ext, dc_diff, cat_in, cat_amp;
  logic [3:0]           cat_size;

  logic                 load, ld_user, ld_last;
  rle_sym_t             ld_sym;
  logic [AMP_WIDTH-1:0] ld_amp;

  // Block framing comes from the internal index, so the input tlast is not needed
  logic unused_tlast;
  assign unused_tlast = zz_tlast;

  assign out_free  = !rle_tvalid || rle_tready;
  assign zz_tready = out_free && (state_q == S_PASS);
  assign accept    = zz_tvalid && zz_tready;
  assign run_ge16  = (run_q >= ZRL_SPAN);

  assign coef_ext  = {zz_tdata[DCT_WIDTH-1], zz_tdata};
  assign hold_ext  = {hold_q[DCT_WIDTH-1], hold_q};
  // First block of a frame predicts from zero
  assign pred_base = zz_tuser ? '0 : dc_pred_q;
  assign dc_diff   = coef_ext - {pred_base[DCT_WIDTH-1], pred_base};

  // One categoriser shared by the DC difference, live AC and held AC paths
  assign cat_in = (state_q == S_HOLD) ? hold_ext :
                  (coef_idx_q == 6'd0) ? dc_diff : coef_ext;

  jpeg_size_cat #(.AMP_WIDTH(AMP_WIDTH)) u_size_cat (
    .value (cat_in),
    .size  (cat_size),
    .amp   (cat_amp)
  );

  // Next-state and symbol selection for the pass-through / ZRL-drain FSM
  always_comb begin
    state_d    = state_q;
    coef_idx_d = coef_idx_q;
    run_d      = run_q;
    dc_pred_d  = dc_pred_q;
    hold_ld    = 1'b0;
    load       = 1'b0;
    ld_sym     = '{run: 4'd0, size: 4'd0};
    ld_amp     = '0;
    ld_user    = 1'b0;
    ld_last    = 1'b0;
    case (state_q)
      S_PASS: begin
        if (accept) begin
          coef_idx_d = coef_idx_q + 6'd1;
          if (coef_idx_q == 6'd0) begin
            load        = 1'b1;
            ld_sym.size = cat_size;
            ld_amp      = cat_amp;
            ld_user     = 1'b1;
            dc_pred_d   = zz_tdata;
            run_d       = 6'd0;
          end else if (zz_tdata == '0) begin
            if (coef_idx_q == LAST_IDX) begin
              load    = 1'b1;
              ld_sym  = EOB_SYM;
              ld_last = 1'b1;
              run_d   = 6'd0;
            end else begin
              run_d = run_q + 6'd1;
            end
          end else if (!run_ge16) begin
            load        = 1'b1;
            ld_sym.run  = run_q[3:0];
            ld_sym.size = cat_size;
            ld_amp      = cat_amp;
            ld_last     = (coef_idx_q == LAST_IDX);
            run_d       = 6'd0;
          end else begin
            // First ZRL goes out with the accepting beat; coefficient waits in hold
            load    = 1'b1;
            ld_sym  = ZRL_SYM;
            run_d   = run_q - ZRL_SPAN;
            hold_ld = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_free) begin
          load = 1'b1;
          if (run_ge16) begin
            ld_sym = ZRL_SYM;
            run_d  = run_q - ZRL_SPAN;
          end else begin
            ld_sym.run  = run_q[3:0];
            ld_sym.size = cat_size;
            ld_amp      = cat_amp;
            ld_last     = hold_last_q;
            run_d       = 6'd0;
            state_d     = S_PASS;
          end
        end
      end
      default: state_d = S_PASS;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_PASS;
    else       state_q <= state_d;
  end

  // Block context: index, zero run, DC predictor and the held coefficient
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      coef_idx_q  <= 6'd0;
      run_q       <= 6'd0;
      dc_pred_q   <= '0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
    end else begin
      coef_idx_q <= coef_idx_d;
      run_q      <= run_d;
      dc_pred_q  <= dc_pred_d;
      if (hold_ld) begin
        hold_q      <= zz_tdata;
        hold_last_q <= (coef_idx_q == LAST_IDX);
      end
    end
  end

  // Single-stage output register; contents frozen while stalled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rle_tvalid <= 1'b0;
      rle_tdata  <= '0;
      rle_tuser  <= 1'b0;
      rle_tlast  <= 1'b0;
    end else if (load) begin
      rle_tvalid <= 1'b1;
      rle_tdata  <= {ld_sym, ld_amp};
      rle_tuser  <= ld_user;
      rle_tlast  <= ld_last;
    end else if (rle_tready) begin
      rle_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jpeg_rle_enc.sv
// Self-checking bench for jpeg_rle_enc against a block-level symbol model.
// Stimulus is randomized coefficients and random sink readiness.
// Each scenario task drives blocks and compares every handshaken symbol.
module tb_jpeg_rle_enc;

  localparam int DW = 12;
  localparam int AW = DW + 1;
  localparam int SW = AW + 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          zz_tvalid, zz_tready, zz_tuser, zz_tlast;
  logic [DW-1:0] zz_tdata;
  logic          rle_tvalid, rle_tready, rle_tuser, rle_tlast;
  logic [SW-1:0] rle_tdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int  blk [4][64];
  bit  blk_first [4];
  logic [SW+1:0] exp_q [$];
  int  model_pred = 0;

  int drv_stalls, drv_acc0, col_first;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jpeg_rle_enc #(.DCT_WIDTH(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .zz_tvalid  (zz_tvalid),
    .zz_tready  (zz_tready),
    .zz_tdata   (zz_tdata),
    .zz_tuser   (zz_tuser),
    .zz_tlast   (zz_tlast),
    .rle_tvalid (rle_tvalid),
    .rle_tready (rle_tready),
    .rle_tdata  (rle_tdata),
    .rle_tuser  (rle_tuser),
    .rle_tlast  (rle_tlast)
  );

  // ---------------- reference model ----------------
  function automatic int size_of(input int v);
    int a, n;
    a = (v < 0) ? -v : v;
    n = 0;
    while ((1 << n) <= a) n++;
    return n;
  endfunction

  function automatic int amp_of(input int v, input int n);
    return (v >= 0) ? v : v + (1 << n) - 1;
  endfunction

  function automatic logic [SW+1:0] mk(input int run, input int sz, input int amp,
                                       input bit u, input bit l);
    return {4'(run), 4'(sz), AW'(amp), u, l};
  endfunction

  function automatic void model_block(input int b);
    int d, n, run;
    d = blk[b][0] - (blk_first[b] ? 0 : model_pred);
    n = size_of(d);
    exp_q.push_back(mk(0, n, amp_of(d, n), 1'b1, 1'b0));
    model_pred = blk[b][0];
    run = 0;
    for (int k = 1; k < 64; k++) begin
      if (blk[b][k] == 0) begin
        run++;
        if (k == 63) exp_q.push_back(mk(0, 0, 0, 1'b0, 1'b1));
      end else begin
        while (run >= 16) begin
          exp_q.push_back(mk(15, 0, 0, 1'b0, 1'b0));
          run -= 16;
        end
        n = size_of(blk[b][k]);
        exp_q.push_back(mk(run, n, amp_of(blk[b][k], n), 1'b0, k == 63));
        run = 0;
      end
    end
  endfunction

  function automatic int rnd_nz();
    int v;
    do v = int'($urandom_range(4095)) - 2048; while (v == 0);
    return v;
  endfunction

  task automatic gen_sparse(input int b, input int pct, input bit first);
    for (int k = 0; k < 64; k++)
      blk[b][k] = ($urandom_range(99) < pct) ? rnd_nz() : 0;
    blk_first[b] = first;
  endtask

  task automatic clear_blk(input int b, input bit first);
    for (int k = 0; k < 64; k++) blk[b][k] = 0;
    blk_first[b] = first;
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input int nb, input int gap_pct);
    bit acc;
    int guard;
    drv_stalls = 0;
    drv_acc0 = -1;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 64; k++) begin
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
          @(negedge clk);
          zz_tvalid = 1'b0;
        end
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 500) begin
          @(negedge clk);
          zz_tvalid = 1'b1;
          zz_tdata  = DW'(blk[b][k]);
          zz_tuser  = (k == 0) && blk_first[b];
          zz_tlast  = (k == 63);
          #1;
          if (zz_tready) begin
            acc = 1'b1;
            if (b == 0 && k == 0) drv_acc0 = cyc;
          end else begin
            drv_stalls++;
            guard++;
          end
        end
        if (!acc) begin
          failures++;
          checks++;
          $display("FAIL input_timeout: block %0d beat %0d never accepted, want accepted", b, k);
          b = nb;
          break;
        end
      end
    end
    @(negedge clk);
    zz_tvalid = 1'b0;
    zz_tuser  = 1'b0;
    zz_tlast  = 1'b0;
  endtask

  task automatic collect(input int rdy_pct);
    int budget;
    logic [SW+1:0] obs, e;
    budget = 0;
    col_first = -1;
    while (exp_q.size() > 0 && budget < 3000) begin
      @(negedge clk);
      rle_tready = ($urandom_range(99) < rdy_pct);
      #1;
      budget++;
      if (rle_tvalid && col_first < 0) col_first = cyc;
      if (rle_tvalid && rle_tready) begin
        obs = {rle_tdata, rle_tuser, rle_tlast};
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL sym: got run=%0d size=%0d amp=%h user=%b last=%b, want run=%0d size=%0d amp=%h user=%b last=%b",
                   obs[SW+1:SW-2], obs[SW-3:SW-6], obs[AW+1:2], obs[1], obs[0],
                   e[SW+1:SW-2], e[SW-3:SW-6], e[AW+1:2], e[1], e[0]);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sym_count: %0d symbols missing, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // Runs nb blocks from blk[], then confirms nothing extra appears
  task automatic run_blocks(input int nb, input int rdy_pct, input int gap_pct);
    bit extra;
    for (int b = 0; b < nb; b++) model_block(b);
    fork
      drive(nb, gap_pct);
      collect(rdy_pct);
    join
    rle_tready = 1'b1;
    extra = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (rle_tvalid) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      failures++;
      $display("FAIL no_extra: tvalid=1 after block end, want 0");
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    zz_tvalid = 1'b0; zz_tdata = '0; zz_tuser = 1'b0; zz_tlast = 1'b0;
    rle_tready = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    #1;
    checks++;
    if (rle_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b want 0", rle_tvalid); end
    checks++;
    if (rle_tdata !== '0) begin failures++; $display("FAIL rst_tdata: got %h want 0", rle_tdata); end
    checks++;
    if ({rle_tuser, rle_tlast} !== 2'b00) begin failures++; $display("FAIL rst_user_last: got %b want 00", {rle_tuser, rle_tlast}); end
    checks++;
    if (zz_tready !== 1'b1) begin failures++; $display("FAIL rst_tready: got %b want 1", zz_tready); end
  endtask

  task automatic test_dc_eob();
    clear_blk(0, 1'b1);
    blk[0][0] = 50;
    run_blocks(1, 100, 0);
    checks++;
    if (col_first - drv_acc0 != 1) begin
      failures++;
      $display("FAIL latency: got %0d cycles want 1", col_first - drv_acc0);
    end
  endtask

  task automatic test_neg_ac();
    clear_blk(0, 1'b0);
    blk[0][0] = 47;
    blk[0][1] = -3;
    run_blocks(1, 100, 0);
  endtask

  task automatic test_zrl_one();
    clear_blk(0, 1'b0);
    blk[0][0] = 10;
    blk[0][20] = 5;
    run_blocks(1, 100, 0);
    checks++;
    if (drv_stalls != 1) begin failures++; $display("FAIL zrl1_stall: got %0d stall cycles want 1", drv_stalls); end
  endtask

  task automatic test_zrl_three();
    clear_blk(0, 1'b0);
    blk[0][0] = -7;
    blk[0][63] = 1;
    gen_sparse(1, 30, 1'b0);
    run_blocks(2, 100, 0);
    checks++;
    if (drv_stalls != 3) begin failures++; $display("FAIL zrl3_stall: got %0d stall cycles want 3", drv_stalls); end
  endtask

  task automatic test_alternating();
    for (int k = 0; k < 64; k++) blk[0][k] = (k % 2 == 0) ? 1 : -1;
    blk_first[0] = 1'b0;
    run_blocks(1, 50, 0);
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 64; k++) blk[b][k] = rnd_nz();
      blk_first[b] = 1'b0;
    end
    blk[0][0] = 2047;
    blk[1][0] = -2048;
    blk[2][0] = 2047;
    run_blocks(3, 100, 0);
    checks++;
    if (drv_stalls != 0) begin failures++; $display("FAIL b2b_stall: got %0d stall cycles want 0", drv_stalls); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      gen_sparse(0, 25, it == 0);
      gen_sparse(1, 8, 1'b0);
      run_blocks(2, 60, 20);
    end
  endtask

  task automatic test_reset_mid();
    rle_tready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      zz_tvalid = 1'b1;
      zz_tdata  = (k == 0) ? DW'(33) : '0;
      zz_tuser  = (k == 0);
      #1;
    end
    @(negedge clk);
    rle_tready = 1'b0;
    zz_tvalid  = 1'b1;
    zz_tuser   = 1'b0;
    zz_tdata   = DW'(9);
    #1;
    checks++;
    if (zz_tready !== 1'b1) begin failures++; $display("FAIL mid_accept: tready=%b want 1", zz_tready); end
    @(negedge clk);
    zz_tvalid = 1'b0;
    #1;
    checks++;
    if ({rle_tvalid, rle_tdata} !== {1'b1, 4'd15, 4'd0, AW'(0)}) begin
      failures++;
      $display("FAIL mid_zrl: got valid=%b data=%h want valid=1 data=%h", rle_tvalid, rle_tdata, {4'd15, 4'd0, AW'(0)});
    end
    checks++;
    if (zz_tready !== 1'b0) begin failures++; $display("FAIL mid_hold_ready: got %b want 0", zz_tready); end
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    checks++;
    if (rle_tvalid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b want 0", rle_tvalid); end
    checks++;
    if (zz_tready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready: got %b want 1", zz_tready); end
    rle_tready = 1'b1;
    model_pred = 0;
    // No tuser: predictor and index must both have come back from reset
    gen_sparse(0, 20, 1'b0);
    blk[0][0] = -100;
    run_blocks(1, 70, 10);
    gen_sparse(0, 20, 1'b1);
    run_blocks(1, 70, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_dc_eob();
    test_neg_ac();
    test_zrl_one();
    test_zrl_three();
    test_alternating();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jpeg_rle_enc.md
Name: jpeg_rle_enc

Overview:
- Run-length/category encoder directly downstream of the zig-zag reorder stage.
- Consumes 64 quantized DCT coefficients per 8x8 block in zig-zag order.
- Emits JPEG symbols for the Huffman stage:
  - DC: difference category/amplitude.
  - AC: (run, size, amplitude), plus ZRL (15,0) and EOB (0,0).

Parameters:
- DCT_WIDTH, 12, signed coefficient width on input; legal range 8..14.
- AMP_WIDTH, DCT_WIDTH+1, localparam; amplitude field width, sized for the DC difference.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, synchronous, active-high
- zz_i  axi4_stream_if.slave  tdata DCT_WIDTH, tuser 1  zig-zag coefficients; tuser=1 on coefficient 0 of a frame's first block
- rle_o  axi4_stream_if.master  tdata 8+AMP_WIDTH, tuser 1, tlast 1  symbols; tdata = {run[3:0], size[3:0], amp[AMP_WIDTH-1:0]}; tuser=1 marks DC symbol; tlast=1 on last symbol of block

Behaviour:
- Clock and reset: one clock clk_i; rst_i synchronous, active-high, sampled on the clk_i rising edge.
- Reset values: rle_o.tvalid=0, tdata/tuser/tlast=0; zz_i.tready=1; coef_idx=0, run=0, dc_pred=0, hold register empty.
- Reset mid-block: discards the partial block, any pending ZRLs and the held coefficient; next accepted coefficient is index 0.
- Index tracking: internal coef_idx 0..63 increments per accepted beat and wraps 63->0. zz_i.tlast is ignored.
- Output register: single stage. Loaded when empty or when rle_o.tready=1 in the same cycle.
  - tdata/tuser/tlast hold stable while tvalid=1 and tready=0.
- zz_i.tready = output register free (empty or being consumed) AND no ZRL pending.
- Latency: 1 cycle from accepted beat to symbol valid, for beats that produce a symbol.
- Size/amplitude rule:
  - size = bit length of |v|; size=0 for v=0.
  - amp = v if v>=0, else (v-1) truncated to size bits, zero-extended to AMP_WIDTH.
- Index 0 (DC):
  - If tuser=1, dc_pred is treated as 0 for this block.
  - diff = v - dc_pred, computed in AMP_WIDTH bits.
  - Emit run=0, size(diff), amp(diff), tuser=1.
  - dc_pred <= v.
  - DC is always emitted, even if diff=0 (size=0).
- Index 1..62, v=0: run++ (max 62); no output.
- Index 1..62, v!=0, run<16: emit (run, size, amp); run<=0.
- Index 1..62, v!=0, run>=16:
  - Capture v in the hold register; drop zz_i.tready.
  - Emit ZRL (15,0,amp=0) once per 16 zeros, run-=16 each time.
  - When run<16, emit the held symbol from the hold register; tready returns the cycle after.
  - Max 3 ZRLs. Each ZRL occupies one output-register transfer.
- Index 63, v=0: emit EOB (0,0,0), tlast=1. Trailing run and unemitted ZRLs are discarded. run<=0.
- Index 63, v!=0: pending ZRLs as above, then the symbol with tlast=1. No EOB follows.
- Back-to-back blocks: DC of the next block is accepted without bubble once the output register frees.
- Backpressure: no symbol lost or duplicated under arbitrary rle_o.tready patterns.
- Throughput: 1 coefficient/cycle except during ZRL insertion.

Decomposition:
- Package jpeg_enc_pkg:
  - ZRL and EOB constants.
  - Symbol field offsets (RUN_MSB, SIZE_MSB, AMP_WIDTH function).
  - typedef rle_sym_t.
- Sub-module jpeg_size_cat: combinational, parameterised by AMP_WIDTH.
  - Inputs: signed value.
  - Outputs: size[3:0], amp[AMP_WIDTH-1:0].
  - Instantiated once, shared by the DC and AC paths via a mux.

Test Plan:
- Reset, then block with tuser=1, DC=50, AC all 0 -> (0,6,50,tuser=1); then (0,0,0) EOB with tlast.
- Next block, DC=47, AC[1]=-3, rest 0 -> DC diff -3: (0,2,amp=0b00,tuser=1); (0,2,amp=0b00); EOB tlast.
- AC[1..19]=0, AC[20]=5, rest 0 -> DC symbol; ZRL (15,0); (3,3,5); EOB.
  - zz_i.tready low exactly 1 cycle during ZRL.
- AC[1..62]=0, AC[63]=1 -> DC; ZRL x3; (14,1,1) with tlast; no EOB.
- All 64 coefficients nonzero (alternating +1/-1) under random rle_o.tready -> 64 symbols, run=0 each, tlast only on symbol 64, no data loss.
- Assert rst_i at coefficient 30 with ZRL pending -> rle_o.tvalid=0 next cycle; next tuser=1 block encodes as from cold start (DC diff vs 0).
